// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared types for the registered one-hot decoder (decoder_n_sync).
//   mode_e  : operating mode carried on the 2-bit mode input
//   state_e : top-level control FSM states
//   max_u   : helper for sizing the shared dwell counter
// ----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        ModeLevel = 2'b00,
        ModePulse = 2'b01,
        ModeScan  = 2'b10,
        ModeRsvd  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StHold  = 2'b01,
        StPulse = 2'b10,
        StScan  = 2'b11
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// ----------------------------------------------------------------------------
// dec_dwell_cnt
// Loadable down-counter with zero flag; times both PULSE length and SCAN dwell.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous reset, active low
//   clr_i      : synchronous clear to zero (abort)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, saturating at zero
//   cnt_o      : current count
//   zero_o     : count is zero
// ----------------------------------------------------------------------------
module dec_dwell_cnt #(
    parameter int unsigned CntW = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_n_sync.sv
// ----------------------------------------------------------------------------
// decoder_n_sync
// Registered binary-to-one-hot decoder with valid/ready select input and three
// modes: LEVEL (hold), PULSE (PULSE_LEN-cycle strobe, then done) and SCAN
// (walk from sel up to NUM_OUT-1, SCAN_DWELL cycles each, then done).
// Optional feature: define DECODER_N_SYNC_ERR_EN to add the sticky err output
// (set after an out-of-range sel or reserved mode is accepted; reset clears).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous reset, active low
//   en        : block enable; low forces outputs off and aborts any operation
//   mode      : 00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (runs as LEVEL)
//   sel       : select code (SCAN: start index)
//   sel_valid : sel/mode valid
//   sel_ready : block can accept sel (combinational)
//   y         : one-hot (or all-zero) output
//   busy      : PULSE or SCAN in progress
//   done      : one-cycle pulse on normal PULSE/SCAN completion
//   err       : (DECODER_N_SYNC_ERR_EN only) sticky error flag
// ----------------------------------------------------------------------------
module decoder_n_sync
    import decoder_pkg::*;
#(
    parameter int unsigned NUM_OUT    = 8,
    parameter int unsigned PULSE_LEN  = 4,
    parameter int unsigned SCAN_DWELL = 2,
    localparam int unsigned SEL_W     = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    output logic               sel_ready,
    output logic [NUM_OUT-1:0] y,
    output logic               busy,
    output logic               done
`ifdef DECODER_N_SYNC_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned CNT_W = $clog2(max_u(PULSE_LEN, SCAN_DWELL) + 1);

    // Counter runs len-1 .. 0, so the state lasts exactly len cycles.
    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] ScanLoad  = CNT_W'(SCAN_DWELL - 1);
    localparam logic [SEL_W:0]   NumOutExt = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LastIdx   = SEL_W'(NUM_OUT - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    logic             accept;
    logic             sel_oor;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_unused;

    // Gated by rst_n so nothing looks acceptable while reset is held.
    assign sel_ready = rst_n && en && ((state_q == StIdle) || (state_q == StHold));
    assign accept    = sel_valid && sel_ready;
    assign sel_oor   = ({1'b0, sel} >= NumOutExt);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        if (!en) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else if (accept) begin
            idx_d = sel;
            if (sel_oor) begin
                state_d = StIdle;
            end else begin
                case (mode)
                    ModePulse: begin
                        state_d  = StPulse;
                        cnt_load = 1'b1;
                        cnt_val  = PulseLoad;
                    end
                    ModeScan: begin
                        state_d  = StScan;
                        cnt_load = 1'b1;
                        cnt_val  = ScanLoad;
                    end
                    default: state_d = StHold;
                endcase
            end
        end else begin
            unique case (state_q)
                StPulse: begin
                    if (cnt_zero) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StScan: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = ScanLoad;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    dec_dwell_cnt #(
        .CntW (CNT_W)
    ) u_dwell_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_unused),
        .zero_o     (cnt_zero)
    );

    // Idle never drives a line, which also covers an accepted out-of-range index.
    assign y    = (state_q != StIdle) ? ({{(NUM_OUT-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign busy = (state_q == StPulse) || (state_q == StScan);
    assign done = done_q;

`ifdef DECODER_N_SYNC_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && (sel_oor || (mode == ModeRsvd))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule
